// File: rtl/palette_mapper.sv
// palette_mapper: programmable colour-code to RGB palette for the VGA DAC path.
//
// A DEPTH-entry writable palette is looked up through a 2-stage registered pipeline
// (stage 1: pixel inputs, stage 2: RGB result). Palette updates go through a
// one-entry deferred-write buffer and are only committed on an edge where blank=1,
// so a visible frame never shows a half-updated palette.
//
// Optional feature macro: PALETTE_BLINK_EN (adds frame_tick/wr_blink ports, a
// per-entry blink flag, and a frame counter with parameter BLINK_FRAMES).
//
// Ports:
//   Clk, Reset_n            clock, asynchronous active-low reset
//   pix_valid/colorcode/blank  pixel request
//   wr_valid/wr_ready/wr_addr/wr_rgb  palette write handshake
//   out_valid, VGA_R/G/B    pixel colour, 2 cycles after the request
//   frame_tick, wr_blink    (PALETTE_BLINK_EN only) frame pulse, blink flag for writes
module palette_mapper #(
  parameter int unsigned CODE_W      = 6,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CHAN_W      = 8,
  parameter logic [23:0] DEFAULT_RGB = 24'h404040
`ifdef PALETTE_BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 30
`endif
) (
  input  logic                Clk,
  input  logic                Reset_n,
`ifdef PALETTE_BLINK_EN
  input  logic                frame_tick,
  input  logic                wr_blink,
`endif
  input  logic                pix_valid,
  input  logic [CODE_W-1:0]   colorcode,
  input  logic                blank,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CODE_W-1:0]   wr_addr,
  input  logic [3*CHAN_W-1:0] wr_rgb,
  output logic                out_valid,
  output logic [CHAN_W-1:0]   VGA_R,
  output logic [CHAN_W-1:0]   VGA_G,
  output logic [CHAN_W-1:0]   VGA_B
);

  localparam int unsigned RGB_W = 3 * CHAN_W;

  // MSB-align an 8-bit channel value: truncate or zero-pad low bits.
  function automatic logic [CHAN_W-1:0] to_chan(input logic [7:0] c);
    return CHAN_W'({c, {CHAN_W{1'b0}}} >> 8);
  endfunction

  function automatic logic [RGB_W-1:0] to_rgb(input logic [23:0] v);
    return {to_chan(v[23:16]), to_chan(v[15:8]), to_chan(v[7:0])};
  endfunction

  function automatic logic [23:0] reset_entry(input int unsigned idx);
    case (idx)
      0, 1:    return 24'h000000;
      2:       return 24'h27B212;
      3:       return 24'hD80222;
      4:       return 24'h5DB1F0;
      5:       return 24'hF1FF0A;
      6:       return 24'hB2B2B0;
      7:       return 24'hF27A00;
      8:       return 24'h663300;
      9:       return 24'h8600B3;
      10:      return 24'h000066;
      11:      return 24'hFFFFFF;
      12:      return 24'h70F248;
      14:      return 24'hFFA64D;
      default: return 24'h404040;
    endcase
  endfunction

  localparam logic [RGB_W-1:0] DEFAULT_OUT = to_rgb(DEFAULT_RGB);

  typedef enum logic [0:0] {StIdle, StPend} wr_state_e;

  wr_state_e           state_q, state_d;
  logic [CODE_W-1:0]   pend_addr_q, pend_addr_d;
  logic [RGB_W-1:0]    pend_rgb_q, pend_rgb_d;
  logic [RGB_W-1:0]    pal_q [DEPTH];
  logic [RGB_W-1:0]    pal_d [DEPTH];
  logic                s1_valid_q, s1_blank_q;
  logic [CODE_W-1:0]   s1_code_q;
  logic                out_valid_q;
  logic [RGB_W-1:0]    rgb_q, rgb_d;

  logic                xfer;
  logic                commit;
  logic [RGB_W-1:0]    lut_rgb;
  logic                blink_hide;

  assign xfer   = (state_q == StIdle) && wr_valid;
  assign commit = (state_q == StPend) && blank;

  // Write buffer and palette commit; out-of-range addresses match no entry and drop.
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_rgb_d  = pend_rgb_q;
    pal_d       = pal_q;
    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          state_d     = StPend;
          pend_addr_d = wr_addr;
          pend_rgb_d  = wr_rgb;
        end
      end
      StPend: begin
        if (commit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (commit && (pend_addr_q == CODE_W'(i))) pal_d[i] = pend_rgb_q;
    end
  end

  // Lookup reads pal_q, so a commit on the same edge is seen only by later pixels.
  always_comb begin
    lut_rgb = DEFAULT_OUT;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (s1_code_q == CODE_W'(i)) lut_rgb = pal_q[i];
    end
  end

  always_comb begin
    rgb_d = rgb_q;
    if (s1_valid_q) begin
      rgb_d = (s1_blank_q || blink_hide) ? '0 : lut_rgb;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= StIdle;
      pend_addr_q <= '0;
      pend_rgb_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) pal_q[i] <= to_rgb(reset_entry(i));
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_blank_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_rgb_q  <= pend_rgb_d;
      pal_q       <= pal_d;
      s1_valid_q  <= pix_valid;
      s1_code_q   <= colorcode;
      s1_blank_q  <= blank;
      out_valid_q <= s1_valid_q;
      rgb_q       <= rgb_d;
    end
  end

`ifdef PALETTE_BLINK_EN
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             pend_blink_q, pend_blink_d;
  logic [DEPTH-1:0] blink_flag_q, blink_flag_d;
  logic             lut_blink;

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    pend_blink_d = xfer ? wr_blink : pend_blink_q;
    blink_flag_d = blink_flag_q;
    lut_blink    = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (commit && (pend_addr_q == CODE_W'(i))) blink_flag_d[i] = pend_blink_q;
      if (s1_code_q == CODE_W'(i)) lut_blink = blink_flag_q[i];
    end
  end

  assign blink_hide = blink_phase_q && lut_blink;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pend_blink_q  <= 1'b0;
      blink_flag_q  <= '0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      pend_blink_q  <= pend_blink_d;
      blink_flag_q  <= blink_flag_d;
    end
  end
`else
  assign blink_hide = 1'b0;
`endif

  assign wr_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;

endmodule

// File: tb/tb_palette_mapper.sv
// Self-checking bench for palette_mapper (default build, DEPTH=16, CHAN_W=8).
// The reference model treats each pixel as seeing the palette as it stands right
// after the edge that sampled it, and delivers that colour one edge later.
module tb_palette_mapper;

  logic        Clk;
  logic        Reset_n;
  logic        pix_valid;
  logic [5:0]  colorcode;
  logic        blank;
  logic        wr_valid;
  logic        wr_ready;
  logic [5:0]  wr_addr;
  logic [23:0] wr_rgb;
  logic        out_valid;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  palette_mapper #(
    .CODE_W      (6),
    .DEPTH       (16),
    .CHAN_W      (8),
    .DEFAULT_RGB (24'h404040)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .pix_valid (pix_valid),
    .colorcode (colorcode),
    .blank     (blank),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_rgb    (wr_rgb),
    .out_valid (out_valid),
    .VGA_R     (VGA_R),
    .VGA_G     (VGA_G),
    .VGA_B     (VGA_B)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [23:0] rst_tab [16];
  logic [23:0] pal_m   [16];
  logic        m_pending;
  logic [5:0]  m_addr;
  logic [23:0] m_data;
  logic        pipe_valid;
  logic [23:0] pipe_rgb;
  logic        exp_valid;
  logic [23:0] exp_rgb;
  logic        last_xfer;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pal_m[i] = rst_tab[i];
    m_pending  = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    pipe_valid = 1'b0;
    pipe_rgb   = '0;
    exp_valid  = 1'b0;
    exp_rgb    = '0;
    last_xfer  = 1'b0;
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic [23:0] px;
    @(posedge Clk);
    exp_valid = pipe_valid;
    if (pipe_valid) exp_rgb = pipe_rgb;
    last_xfer = 1'b0;
    if (m_pending && blank) begin
      if (m_addr < 6'd16) pal_m[m_addr[3:0]] = m_data;
      m_pending = 1'b0;
    end else if (!m_pending && wr_valid) begin
      m_pending = 1'b1;
      m_addr    = wr_addr;
      m_data    = wr_rgb;
      last_xfer = 1'b1;
    end
    if (blank)                 px = 24'h000000;
    else if (colorcode >= 16)  px = 24'h404040;
    else                       px = pal_m[colorcode[3:0]];
    pipe_valid = pix_valid;
    pipe_rgb   = px;
    #1;
    check_eq("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    check_eq("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp_rgb});
    check_eq("wr_ready", {31'b0, wr_ready}, {31'b0, !m_pending});
  endtask

  task automatic pix(input logic [5:0] code, input logic blk, input logic vld);
    colorcode = code;
    blank     = blk;
    pix_valid = vld;
    step();
  endtask

  task automatic check_rgb(input string tag, input logic [23:0] exp);
    check_eq(tag, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp});
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_wr_ready", {31'b0, wr_ready}, 32'd1);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_rgb("rst_rgb", 24'h000000);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    rst_tab = '{24'h000000, 24'h000000, 24'h27B212, 24'hD80222,
                24'h5DB1F0, 24'hF1FF0A, 24'hB2B2B0, 24'hF27A00,
                24'h663300, 24'h8600B3, 24'h000066, 24'hFFFFFF,
                24'h70F248, 24'h404040, 24'hFFA64D, 24'h404040};
    pix_valid = 1'b0;
    colorcode = '0;
    blank     = 1'b0;
    wr_valid  = 1'b0;
    wr_addr   = '0;
    wr_rgb    = '0;
    #2;
    do_reset();

    // Basic lookups, blanking, and hold on non-valid cycles.
    pix(6'd2, 1'b0, 1'b1);
    pix(6'd3, 1'b0, 1'b1);
    check_rgb("code2", 24'h27B212);
    pix(6'd14, 1'b0, 1'b1);
    check_rgb("code3", 24'hD80222);
    pix(6'd15, 1'b0, 1'b1);
    check_rgb("code14", 24'hFFA64D);
    pix(6'd11, 1'b1, 1'b1);
    check_rgb("code15", 24'h404040);
    check_eq("code15_valid", {31'b0, out_valid}, 32'd1);
    pix(6'd4, 1'b0, 1'b1);
    check_rgb("blank11", 24'h000000);
    check_eq("blank11_valid", {31'b0, out_valid}, 32'd1);
    pix(6'd0, 1'b0, 1'b0);
    check_rgb("code4", 24'h5DB1F0);
    pix(6'd0, 1'b0, 1'b0);
    check_eq("hold_valid", {31'b0, out_valid}, 32'd0);
    check_rgb("hold_rgb", 24'h5DB1F0);

    // Deferred write waits for blank.
    wr_valid = 1'b1; wr_addr = 6'd5; wr_rgb = 24'h123456;
    pix(6'd5, 1'b0, 1'b1);
    wr_valid = 1'b0;
    check_eq("wr1_busy", {31'b0, wr_ready}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      pix(6'd5, 1'b0, 1'b1);
      check_rgb("wr1_old", 24'hF1FF0A);
      check_eq("wr1_busy_hold", {31'b0, wr_ready}, 32'd0);
    end
    pix(6'd5, 1'b1, 1'b0);
    check_eq("wr1_ready_after", {31'b0, wr_ready}, 32'd1);
    pix(6'd5, 1'b0, 1'b1);
    pix(6'd0, 1'b0, 1'b0);
    check_rgb("wr1_new", 24'h123456);

    // Commit edge coincides with stage-2 lookup of the same entry.
    wr_valid = 1'b1; wr_addr = 6'd5; wr_rgb = 24'hABCDEF;
    pix(6'd0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    pix(6'd5, 1'b0, 1'b1);
    pix(6'd5, 1'b1, 1'b1);
    check_rgb("coinc_old", 24'h123456);
    pix(6'd5, 1'b0, 1'b1);
    check_rgb("coinc_blank", 24'h000000);
    pix(6'd0, 1'b0, 1'b0);
    check_rgb("coinc_new", 24'hABCDEF);

    // Out-of-range write is accepted and dropped.
    wr_valid = 1'b1; wr_addr = 6'd20; wr_rgb = 24'h111111;
    pix(6'd0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    check_eq("wr20_busy", {31'b0, wr_ready}, 32'd0);
    pix(6'd0, 1'b1, 1'b0);
    check_eq("wr20_ready", {31'b0, wr_ready}, 32'd1);
    pix(6'd20, 1'b0, 1'b1);
    pix(6'd0, 1'b0, 1'b0);
    check_rgb("code20", 24'h404040);

    // Reset while a write is pending.
    wr_valid = 1'b1; wr_addr = 6'd3; wr_rgb = 24'h00FF00;
    pix(6'd0, 1'b0, 1'b0);
    wr_valid = 1'b0;
    pix(6'd0, 1'b0, 1'b0);
    check_eq("pend_busy", {31'b0, wr_ready}, 32'd0);
    #2;
    do_reset();
    pix(6'd3, 1'b1, 1'b0);
    pix(6'd3, 1'b0, 1'b1);
    pix(6'd0, 1'b0, 1'b0);
    check_rgb("rst_entry3", 24'hD80222);
    pix(6'd5, 1'b0, 1'b1);
    pix(6'd0, 1'b0, 1'b0);
    check_rgb("rst_entry5", 24'hF1FF0A);

    // Randomized traffic against the model; write request held until transfer.
    for (int c = 0; c < 3000; c++) begin
      if (!wr_valid || last_xfer) begin
        wr_valid = ($urandom_range(0, 3) == 0);
        wr_addr  = 6'($urandom_range(0, 31));
        wr_rgb   = 24'($urandom);
      end
      pix(6'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
